// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the AD9252 SPI arbiter: FSM encoding,
// AD9252 command words and default timing limits.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_FINISH  = 3'd5
  } arb_state_t;

  localparam logic [31:0] CMD_TEST_MODE = 32'h000D0C0C;
  localparam logic [31:0] CMD_WORK_MODE = 32'h000D0000;
  localparam logic [31:0] CMD_UPDATE    = 32'h00FF0101;

  localparam int          BUSY_WAIT_DEFAULT = 16;
  localparam logic [23:0] TIMEOUT_DEFAULT   = 24'h400;

endpackage

// File: rtl/adc_spi_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter, bundled.
// master = arbiter view, slave = requesters plus SPI master view.
interface adc_spi_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [DW-1:0]      adc_data;
  logic               start;
  logic               busy_9252;

  modport master (
    input  req, req_data, busy_9252,
    output ack, done, err, adc_data, start
  );

  modport slave (
    output req, req_data, busy_9252,
    input  ack, done, err, adc_data, start
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NREQ; returns one-hot grant and binary index.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx,
  output logic            found
);
  logic [7:0] req_pad;
  logic [2:0] cand [NREQ];

  assign req_pad = 8'(req);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi]  = 3'((32'(ptr) + gi) % NREQ);
      assign grant[gi] = found && (idx == 3'(gi));
    end
  endgenerate

  // Scan from the farthest candidate down so the one closest to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_pad[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end
endmodule

// File: rtl/adc_spi_arbiter.sv
// Round-robin arbiter sharing one AD9252 SPI master among NREQ requesters.
// Optional busy-high timeout in WAIT_LO: define ADC_SPI_TIMEOUT_EN.
module adc_spi_arbiter
  import adc_spi_pkg::*;
#(
  parameter int          NREQ      = 3,
  parameter int          DW        = 32,
  parameter int          BUSY_WAIT = BUSY_WAIT_DEFAULT,
  parameter logic [23:0] TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  adc_spi_arbiter_if.master  bus,
  output logic [2:0]         owner,
  output logic [2:0]         arb_state
);
`ifdef ADC_SPI_TIMEOUT_EN
  localparam int CNT_W = 24;
`else
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);
`endif

  // Unsupported configurations fail elaboration on a missing module.
  generate
    if ((NREQ < 2) || (NREQ > 8) || (BUSY_WAIT < 2) || (TIMEOUT < 24'd2)) begin : g_cfg_invalid
      adc_spi_arbiter_bad_config u_bad_config ();
    end
  endgenerate

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_flag_reg, err_flag_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [2:0]       owner_reg, owner_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [DW-1:0]    data_reg, data_next;
  logic             start_reg;
  logic [NREQ-1:0]  ack_reg, done_reg, err_reg;
`ifdef ADC_SPI_TIMEOUT_EN
  logic             drain_reg, drain_next;
`endif

  logic [NREQ-1:0]  arb_grant;
  logic [2:0]       arb_idx;
  logic             arb_found;
  logic [DW-1:0]    slot_word [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NREQ) begin : g_used
        assign slot_word[gi] = bus.req_data[gi*DW +: DW];
      end else begin : g_pad
        assign slot_word[gi] = '0;
      end
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    err_flag_next = err_flag_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    grant_next    = grant_reg;
    data_next     = data_reg;
`ifdef ADC_SPI_TIMEOUT_EN
    drain_next    = drain_reg;
`endif
    case (state_reg)
      S_IDLE: begin
`ifdef ADC_SPI_TIMEOUT_EN
        // After a timeout the master may still be mid-op; let it drain first.
        if (drain_reg && !bus.busy_9252) drain_next = 1'b0;
        if (|bus.req && !bus.busy_9252 && !drain_reg) state_next = S_ARB;
`else
        if (|bus.req && !bus.busy_9252) state_next = S_ARB;
`endif
      end
      S_ARB: begin
        if (arb_found) begin
          data_next  = slot_word[arb_idx];
          owner_next = arb_idx;
          grant_next = arb_grant;
          state_next = S_LAUNCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LAUNCH: begin
        ptr_next   = (owner_reg == 3'(NREQ - 1)) ? 3'd0 : owner_reg + 3'd1;
        cnt_next   = CNT_W'(BUSY_WAIT);
        state_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.busy_9252) begin
          state_next = S_WAIT_LO;
`ifdef ADC_SPI_TIMEOUT_EN
          cnt_next   = CNT_W'(TIMEOUT);
`endif
        end else if (cnt_reg == CNT_W'(1)) begin
          state_next    = S_FINISH;
          err_flag_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!bus.busy_9252) begin
          state_next = S_FINISH;
`ifdef ADC_SPI_TIMEOUT_EN
        end else if (cnt_reg == CNT_W'(1)) begin
          state_next    = S_FINISH;
          err_flag_next = 1'b1;
          drain_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
`endif
        end
      end
      S_FINISH: begin
        err_flag_next = 1'b0;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      err_flag_reg <= 1'b0;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      grant_reg    <= '0;
      data_reg     <= '0;
      start_reg    <= 1'b0;
      ack_reg      <= '0;
      done_reg     <= '0;
      err_reg      <= '0;
`ifdef ADC_SPI_TIMEOUT_EN
      drain_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      err_flag_reg <= err_flag_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      grant_reg    <= grant_next;
      data_reg     <= data_next;
      // Strobes are registered so they coincide with the LAUNCH state.
      start_reg    <= (state_next == S_LAUNCH);
      ack_reg      <= (state_next == S_LAUNCH) ? grant_next : '0;
      done_reg     <= (state_reg == S_FINISH) ? grant_reg : '0;
      err_reg      <= (state_reg == S_FINISH && err_flag_reg) ? grant_reg : '0;
`ifdef ADC_SPI_TIMEOUT_EN
      drain_reg    <= drain_next;
`endif
    end
  end

  assign bus.start    = start_reg;
  assign bus.ack      = ack_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;
  assign bus.adc_data = data_reg;
  assign owner        = owner_reg;
  assign arb_state    = state_reg;
endmodule

// File: tb/tb_adc_spi_arbiter.sv
// Directed bench for adc_spi_arbiter with a simple SPI-master busy model.
// Covers the timeout path only when built with ADC_SPI_TIMEOUT_EN.
module tb_adc_spi_arbiter;
  import adc_spi_pkg::*;

  localparam int NREQ = 3;
  localparam int DW = 32;
  localparam int BUSY_WAIT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] owner, arb_state;

  adc_spi_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  adc_spi_arbiter #(.NREQ(NREQ), .DW(DW), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .owner(owner), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // busy model controls (written only by the main initial block)
  int busy_len = 5;
  bit never_busy = 0;
  bit force_en = 0;
  bit force_val = 0;

  // monitor records (written only by the monitor)
  int n_start = 0, n_done = 0, overlap = 0;
  bit pend = 0;
  logic [31:0] start_word [64];
  logic [2:0]  start_own [64];
  int          start_cyc [64];
  logic [2:0]  ack_vec [64];
  logic [2:0]  done_vec [64];
  logic [2:0]  err_vec [64];
  int          done_cyc [64];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI master model: busy rises right after start, stays high busy_len cycles.
  initial begin
    int bcnt;
    bcnt = 0;
    bus.busy_9252 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.busy_9252 = 1'b0;
        bcnt = 0;
      end else if (force_en) begin
        bus.busy_9252 = force_val;
      end else if (bcnt > 0) begin
        bcnt--;
        bus.busy_9252 = (bcnt != 0);
      end else if (bus.start && !never_busy) begin
        bus.busy_9252 = 1'b1;
        bcnt = busy_len;
      end else begin
        bus.busy_9252 = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      pend = 0;
    end else begin
      if (bus.start && n_start < 64) begin
        if (pend) overlap++;
        pend = 1;
        start_word[n_start] = bus.adc_data;
        start_own[n_start] = owner;
        start_cyc[n_start] = cyc;
        ack_vec[n_start] = bus.ack;
        n_start++;
      end
      if (|bus.done && n_done < 64) begin
        pend = 0;
        done_vec[n_done] = bus.done;
        err_vec[n_done] = bus.err;
        done_cyc[n_done] = cyc;
        $display("txn %0d: done=%b err=%b word=%h cycle=%0d", n_done, bus.done, bus.err, bus.adc_data, cyc);
        n_done++;
      end
    end
  end

  task automatic run_until_done(input int target, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (|bus.ack) bus.req = bus.req & ~bus.ack;
      if (n_done >= target) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({bus.ack, bus.done, bus.err} !== 9'd0) begin failures++; $display("FAIL reset_hs: got %b expected 0", {bus.ack, bus.done, bus.err}); end
    checks++; if ({bus.start, bus.adc_data} !== 33'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", {bus.start, bus.adc_data}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({owner, arb_state} !== 6'd0) begin failures++; $display("FAIL reset_state: got %b expected 0", {owner, arb_state}); end
  endtask

  task automatic test_single();
    int sb, db; bit ok;
    sb = n_start; db = n_done; busy_len = 5;
    bus.req_data = {32'h0, 32'h0, CMD_TEST_MODE};
    bus.req = 3'b001;
    run_until_done(db + 1, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got no done expected done"); end
    checks++; if (n_start !== sb + 1) begin failures++; $display("FAIL single_starts: got %0d expected %0d", n_start - sb, 1); end
    checks++; if (start_word[sb] !== 32'h000D0C0C) begin failures++; $display("FAIL single_word: got %h expected 000d0c0c", start_word[sb]); end
    checks++; if (ack_vec[sb] !== 3'b001) begin failures++; $display("FAIL single_ack: got %b expected 001", ack_vec[sb]); end
    checks++; if (done_vec[db] !== 3'b001 || err_vec[db] !== 3'b000) begin failures++; $display("FAIL single_done: got done=%b err=%b expected 001/000", done_vec[db], err_vec[db]); end
    checks++; if (done_cyc[db] - start_cyc[sb] !== 7) begin failures++; $display("FAIL single_latency: got %0d expected 7", done_cyc[db] - start_cyc[sb]); end
    @(negedge clk);
    checks++; if (arb_state !== 3'd0) begin failures++; $display("FAIL single_idle: got %0d expected 0", arb_state); end
  endtask

  task automatic test_round_robin();
    int sb, db; bit ok;
    logic [31:0] exp_word [3];
    apply_reset();
    sb = n_start; db = n_done; busy_len = 40;
    exp_word[0] = CMD_TEST_MODE; exp_word[1] = CMD_WORK_MODE; exp_word[2] = CMD_UPDATE;
    bus.req_data = {CMD_UPDATE, CMD_WORK_MODE, CMD_TEST_MODE};
    bus.req = 3'b111;
    run_until_done(db + 3, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d dones expected 3", n_done - db); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (start_word[sb+k] !== exp_word[k] || start_own[sb+k] !== 3'(k)) begin failures++; $display("FAIL rr_order%0d: got owner %0d word %h expected owner %0d word %h", k, start_own[sb+k], start_word[sb+k], k, exp_word[k]); end
    end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL rr_overlap: got %0d expected 0", overlap); end
    // pointer wrapped to 0: slot 0 beats slot 1
    busy_len = 3;
    bus.req_data = {32'h0, 32'h11112222, 32'h33334444};
    bus.req = 3'b011;
    run_until_done(db + 4, 60, ok);
    checks++; if (!ok || start_own[sb+3] !== 3'd0) begin failures++; $display("FAIL rr_wrap: got owner %0d expected 0", start_own[sb+3]); end
    run_until_done(db + 5, 60, ok);
    checks++; if (!ok || start_word[sb+4] !== 32'h11112222) begin failures++; $display("FAIL rr_second: got %h expected 11112222", start_word[sb+4]); end
  endtask

  task automatic test_no_busy();
    int sb, db; bit ok;
    sb = n_start; db = n_done; never_busy = 1;
    bus.req_data = {32'hABCD0001, 32'h0, 32'h0};
    bus.req = 3'b100;
    run_until_done(db + 1, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nobusy_timeout: got no done expected done"); end
    checks++; if (done_vec[db] !== 3'b100 || err_vec[db] !== 3'b100) begin failures++; $display("FAIL nobusy_err: got done=%b err=%b expected 100/100", done_vec[db], err_vec[db]); end
    checks++; if (done_cyc[db] - start_cyc[sb] !== BUSY_WAIT + 2) begin failures++; $display("FAIL nobusy_latency: got %0d expected %0d", done_cyc[db] - start_cyc[sb], BUSY_WAIT + 2); end
    checks++; if (arb_state !== 3'd0) begin failures++; $display("FAIL nobusy_idle: got %0d expected 0", arb_state); end
    never_busy = 0;
  endtask

  task automatic test_stuck_busy();
    int sb, db, i; bit ok;
    sb = n_start; db = n_done;
    bus.req_data = {32'h0, 32'h0, 32'h00C0FFEE};
    bus.req = 3'b001;
    for (i = 0; i < 20 && !(|bus.ack); i++) @(negedge clk);
    checks++; if (!(|bus.ack)) begin failures++; $display("FAIL stuck_ack: got no ack expected ack"); end
    bus.req = '0;
    force_val = 1; force_en = 1;
`ifdef ADC_SPI_TIMEOUT_EN
    run_until_done(db + 1, 32'h400 + 60, ok);
    checks++; if (!ok || done_vec[db] !== 3'b001 || err_vec[db] !== 3'b001) begin failures++; $display("FAIL timeout_err: got done=%b err=%b expected 001/001", done_vec[db], err_vec[db]); end
    bus.req_data = {32'h0, 32'h5A5A5A5A, 32'h0};
    bus.req = 3'b010;
    repeat (40) @(negedge clk);
    checks++; if (n_start !== sb + 1) begin failures++; $display("FAIL timeout_hold: got %0d starts expected 1", n_start - sb); end
    force_en = 0;
    run_until_done(db + 2, 60, ok);
    checks++; if (!ok || start_own[sb+1] !== 3'd1 || err_vec[db+1] !== 3'b000) begin failures++; $display("FAIL timeout_next: got owner %0d err %b expected 1/000", start_own[sb+1], err_vec[db+1]); end
`else
    repeat (200) @(negedge clk);
    checks++; if (n_done !== db || arb_state !== 3'd4) begin failures++; $display("FAIL stuck_wait: got dones %0d state %0d expected 0/4", n_done - db, arb_state); end
    force_en = 0;
    run_until_done(db + 1, 20, ok);
    checks++; if (!ok || done_vec[db] !== 3'b001 || err_vec[db] !== 3'b000) begin failures++; $display("FAIL stuck_done: got done=%b err=%b expected 001/000", done_vec[db], err_vec[db]); end
`endif
  endtask

  task automatic test_reset_mid();
    int sb, db, i; bit ok;
    sb = n_start; db = n_done; busy_len = 200;
    bus.req_data = {32'h0, CMD_UPDATE, 32'h0};
    bus.req = 3'b010;
    for (i = 0; i < 30 && arb_state !== 3'd4; i++) begin
      @(negedge clk);
      if (|bus.ack) bus.req = bus.req & ~bus.ack;
    end
    checks++; if (arb_state !== 3'd4) begin failures++; $display("FAIL rstmid_reach: got state %0d expected 4", arb_state); end
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    checks++; if ({bus.ack, bus.done, bus.err, bus.start} !== 10'd0) begin failures++; $display("FAIL rstmid_strobes: got %b expected 0", {bus.ack, bus.done, bus.err, bus.start}); end
    checks++; if ({bus.adc_data, owner, arb_state} !== 38'd0) begin failures++; $display("FAIL rstmid_regs: got %h expected 0", {bus.adc_data, owner, arb_state}); end
    @(negedge clk);
    reset = 1'b0;
    busy_len = 6;
    bus.req_data = {32'h0, 32'h0, CMD_WORK_MODE};
    bus.req = 3'b001;
    run_until_done(db + 1, 60, ok);
    checks++; if (!ok || n_start !== sb + 2 || start_word[sb+1] !== CMD_WORK_MODE) begin failures++; $display("FAIL rstmid_restart: got starts %0d word %h expected 2/%h", n_start - sb, start_word[sb+1], CMD_WORK_MODE); end
    checks++; if (done_vec[db] !== 3'b001 || err_vec[db] !== 3'b000) begin failures++; $display("FAIL rstmid_done: got done=%b err=%b expected 001/000", done_vec[db], err_vec[db]); end
  endtask

  task automatic test_busy_idle();
    int sb, db, fall_cyc, i; bit ok;
    sb = n_start; db = n_done; busy_len = 4;
    force_val = 1; force_en = 1;
    repeat (2) @(negedge clk);
    bus.req_data = {32'h0, 32'h0BAD0F0D, 32'h0};
    bus.req = 3'b010;
    repeat (10) @(negedge clk);
    checks++; if (n_start !== sb || arb_state !== 3'd0) begin failures++; $display("FAIL busyidle_hold: got starts %0d state %0d expected 0/0", n_start - sb, arb_state); end
    force_en = 0;
    @(negedge clk);
    fall_cyc = cyc;
    for (i = 0; i < 10 && n_start == sb; i++) @(negedge clk);
    checks++; if (n_start == sb || start_cyc[sb] - fall_cyc < 1 || start_cyc[sb] - fall_cyc > 3) begin failures++; $display("FAIL busyidle_start: got delay %0d expected 1..3", start_cyc[sb] - fall_cyc); end
    run_until_done(db + 1, 60, ok);
    checks++; if (!ok || start_word[sb] !== 32'h0BAD0F0D || done_vec[db] !== 3'b010) begin failures++; $display("FAIL busyidle_done: got word %h done %b expected 0bad0f0d/010", start_word[sb], done_vec[db]); end
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_no_busy();
    test_stuck_busy();
    test_reset_mid();
    test_busy_idle();
    checks++; if (overlap !== 0) begin failures++; $display("FAIL final_overlap: got %0d expected 0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
